// File: rtl/pc060ha_nibble_mailbox.sv
`default_nettype none
// ============================================================================
// Module   : pc060ha_nibble_mailbox
// Brief    : One-direction nibble mailbox with per-slot full flags, strobe
//            synchronizers and a level IRQ to the reader.
// Revision : 1.0 - initial release
// ============================================================================
module pc060ha_nibble_mailbox #(
    parameter int DW       = 4,
    parameter int SLOTS    = 4,
    parameter int PW       = 2,
    parameter int SYNC     = 2,
    parameter int IRQ_SLOT = 3
) (
    input  logic             CLK,
    input  logic             RESETTICK,
    input  logic             WSTB,
    input  logic             WSEL,
    input  logic [DW-1:0]    WDIN,
    input  logic             RSTB,
    input  logic             RSEL,
    input  logic [DW-1:0]    RDIN,
    output logic [DW-1:0]    RDOUT,
    output logic             RDVALID,
    output logic [SLOTS-1:0] STATUS,
    output logic             OVF,
    output logic             IRQ,
    output logic [SLOTS-1:0] SETPULSE,
    output logic [SLOTS-1:0] CLRPULSE
);

    localparam logic [PW-1:0]    c_ptr_one  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [SLOTS-1:0] c_slot_one = {{(SLOTS-1){1'b0}}, 1'b1};

    logic             w_wsync, w_rsync;
    logic             r_whist, r_rhist;
    logic             w_wev, w_rev;
    logic             w_wdata, w_wptrw, w_rdata, w_rctl;
    logic             w_same, w_ovf_set;
    logic [SLOTS-1:0] w_set_vec, w_clr_vec;
    logic [PW-1:0]    r_wptr, r_rptr;
    logic [DW-1:0]    r_slot [SLOTS];
    logic [DW-1:0]    r_rdout;
    logic             r_rdvalid, r_ovf;
    logic [SLOTS-1:0] r_status, r_setpulse, r_clrpulse;
    logic             w_unused_rdin;

    // Synchronizers preset to 1 so a strobe held across reset is not an event
    generate
        if (SYNC > 0) begin : g_sync
            logic [SYNC-1:0] r_wsync, r_rsync;
            always_ff @(posedge CLK or posedge RESETTICK) begin
                if (RESETTICK) begin
                    r_wsync <= '1;
                    r_rsync <= '1;
                end else begin
                    r_wsync[0] <= WSTB;
                    r_rsync[0] <= RSTB;
                    for (int i = 1; i < SYNC; i++) begin
                        r_wsync[i] <= r_wsync[i-1];
                        r_rsync[i] <= r_rsync[i-1];
                    end
                end
            end
            assign w_wsync = r_wsync[SYNC-1];
            assign w_rsync = r_rsync[SYNC-1];
        end else begin : g_nosync
            assign w_wsync = WSTB;
            assign w_rsync = RSTB;
        end
    endgenerate

    always_ff @(posedge CLK or posedge RESETTICK) begin
        if (RESETTICK) begin
            r_whist <= 1'b1;
            r_rhist <= 1'b1;
        end else begin
            r_whist <= w_wsync;
            r_rhist <= w_rsync;
        end
    end

    assign w_wev   = w_wsync & ~r_whist;
    assign w_rev   = w_rsync & ~r_rhist;
    assign w_wdata = w_wev & ~WSEL;
    assign w_wptrw = w_wev & WSEL;
    assign w_rdata = w_rev & ~RSEL;
    assign w_rctl  = w_rev & RSEL;

    // A write into a slot being drained in the same cycle is not an overwrite
    assign w_same    = w_wdata & w_rdata & (r_wptr == r_rptr);
    assign w_ovf_set = w_wdata & r_status[r_wptr] & ~w_same;
    assign w_set_vec = w_wdata ? (c_slot_one << r_wptr) : '0;
    assign w_clr_vec = w_rdata ? (c_slot_one << r_rptr) : '0;

    always_ff @(posedge CLK or posedge RESETTICK) begin
        if (RESETTICK) begin
            for (int i = 0; i < SLOTS; i++) r_slot[i] <= '0;
        end else if (w_wdata) begin
            r_slot[r_wptr] <= WDIN;
        end
    end

    always_ff @(posedge CLK or posedge RESETTICK) begin
        if (RESETTICK) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_rdout    <= '0;
            r_rdvalid  <= 1'b0;
            r_ovf      <= 1'b0;
            r_status   <= '0;
            r_setpulse <= '0;
            r_clrpulse <= '0;
        end else begin
            r_rdvalid  <= w_rdata;
            r_setpulse <= w_set_vec;
            r_clrpulse <= w_clr_vec;
            // Set after clear so a same-slot write wins
            r_status   <= (r_status & ~w_clr_vec) | w_set_vec;

            if (w_wptrw)
                r_wptr <= WDIN[PW-1:0];
            else if (w_wdata)
                r_wptr <= r_wptr + c_ptr_one;

            if (w_rctl)
                r_rptr <= RDIN[PW-1:0];
            else if (w_rdata)
                r_rptr <= r_rptr + c_ptr_one;

            if (w_rdata)
                r_rdout <= r_slot[r_rptr];

            if (w_ovf_set)
                r_ovf <= 1'b1;
            else if (w_rctl & RDIN[DW-1])
                r_ovf <= 1'b0;
        end
    end

    // Middle bits of RDIN carry no meaning
    assign w_unused_rdin = ^RDIN;

    assign RDOUT    = r_rdout;
    assign RDVALID  = r_rdvalid;
    assign STATUS   = r_status;
    assign OVF      = r_ovf;
    assign IRQ      = r_status[IRQ_SLOT];
    assign SETPULSE = r_setpulse;
    assign CLRPULSE = r_clrpulse;

endmodule
`default_nettype wire

// File: tb/tb_pc060ha_nibble_mailbox.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc060ha_nibble_mailbox
// Brief    : Scoreboard bench for the nibble mailbox (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc060ha_nibble_mailbox;

    logic       clk = 1'b0;
    logic       rst_tick;
    logic       wstb, wsel, rstb, rsel;
    logic [3:0] wdin, rdin;
    logic [3:0] rdout;
    logic       rdvalid, ovf, irq;
    logic [3:0] status, setpulse, clrpulse;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] m_slot [4];
    logic [3:0] m_stat;
    logic [1:0] m_wptr, m_rptr;
    logic       m_ovf;
    logic [3:0] rd_q [$];
    logic [3:0] set_q [$];
    logic [3:0] clr_q [$];

    always #5 clk = ~clk;

    pc060ha_nibble_mailbox dut (
        .CLK       (clk),
        .RESETTICK (rst_tick),
        .WSTB      (wstb),
        .WSEL      (wsel),
        .WDIN      (wdin),
        .RSTB      (rstb),
        .RSEL      (rsel),
        .RDIN      (rdin),
        .RDOUT     (rdout),
        .RDVALID   (rdvalid),
        .STATUS    (status),
        .OVF       (ovf),
        .IRQ       (irq),
        .SETPULSE  (setpulse),
        .CLRPULSE  (clrpulse)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_slot[i] = 4'h0;
        m_stat = 4'h0;
        m_wptr = 2'd0;
        m_rptr = 2'd0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_w(input logic sel, input logic [3:0] din, input bit same);
        if (sel) begin
            m_wptr = din[1:0];
        end else begin
            if (m_stat[m_wptr] && !same) m_ovf = 1'b1;
            m_slot[m_wptr] = din;
            m_stat[m_wptr] = 1'b1;
            set_q.push_back(4'b0001 << m_wptr);
            m_wptr = m_wptr + 2'd1;
        end
    endtask

    task automatic model_r(input logic sel, input logic [3:0] din);
        if (sel) begin
            m_rptr = din[1:0];
            if (din[3]) m_ovf = 1'b0;
        end else begin
            rd_q.push_back(m_slot[m_rptr]);
            m_stat[m_rptr] = 1'b0;
            clr_q.push_back(4'b0001 << m_rptr);
            m_rptr = m_rptr + 2'd1;
        end
    endtask

    task automatic check_state();
        chk("STATUS", status, m_stat);
        chk("IRQ", irq, m_stat[3]);
        chk("OVF", ovf, m_ovf);
        chk("rd_q_drained", rd_q.size(), 0);
        chk("set_q_drained", set_q.size(), 0);
        chk("clr_q_drained", clr_q.size(), 0);
    endtask

    task automatic fire(input bit dw, input bit dr);
        @(negedge clk);
        if (dw) wstb = 1'b1;
        if (dr) rstb = 1'b1;
        repeat (4) @(negedge clk);
        wstb = 1'b0;
        rstb = 1'b0;
        repeat (4) @(negedge clk);
        check_state();
    endtask

    task automatic wr(input logic sel, input logic [3:0] din);
        model_w(sel, din, 1'b0);
        wsel = sel;
        wdin = din;
        fire(1'b1, 1'b0);
    endtask

    task automatic rd(input logic sel, input logic [3:0] din);
        model_r(sel, din);
        rsel = sel;
        rdin = din;
        fire(1'b0, 1'b1);
    endtask

    task automatic both(input logic ws, input logic [3:0] wd, input logic rs, input logic [3:0] rd_in);
        bit same;
        same = (ws == 1'b0) && (rs == 1'b0) && (m_wptr == m_rptr);
        model_r(rs, rd_in);
        model_w(ws, wd, same);
        wsel = ws;
        wdin = wd;
        rsel = rs;
        rdin = rd_in;
        fire(1'b1, 1'b1);
    endtask

    // Scoreboard: every output pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst_tick) begin
            if (rdvalid) begin
                chk("rd_pending", rd_q.size() != 0, 1);
                if (rd_q.size() != 0) chk("RDOUT", rdout, rd_q.pop_front());
            end
            if (setpulse != 4'h0) begin
                chk("set_pending", set_q.size() != 0, 1);
                if (set_q.size() != 0) chk("SETPULSE", setpulse, set_q.pop_front());
            end
            if (clrpulse != 4'h0) begin
                chk("clr_pending", clr_q.size() != 0, 1);
                if (clr_q.size() != 0) chk("CLRPULSE", clrpulse, clr_q.pop_front());
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_RDOUT"}, rdout, 0);
        chk({tag, "_RDVALID"}, rdvalid, 0);
        chk({tag, "_STATUS"}, status, 0);
        chk({tag, "_OVF"}, ovf, 0);
        chk({tag, "_IRQ"}, irq, 0);
        chk({tag, "_SETPULSE"}, setpulse, 0);
        chk({tag, "_CLRPULSE"}, clrpulse, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        rst_tick = 1'b1;
        wstb = 1'b1;
        wsel = 1'b0;
        wdin = 4'h3;
        rstb = 1'b0;
        rsel = 1'b0;
        rdin = 4'h0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_tick = 1'b0;
        repeat (6) @(negedge clk);
        chk("held_strobe_STATUS", status, 0);
        wstb = 1'b0;
        repeat (4) @(negedge clk);
        check_state();

        // Action must land exactly SYNC+1 edges after the rise
        model_w(1'b0, 4'h5, 1'b0);
        wsel = 1'b0;
        wdin = 4'h5;
        wstb = 1'b1;
        @(negedge clk);
        chk("early_edge1", status, 0);
        @(negedge clk);
        chk("early_edge2", status, 0);
        @(negedge clk);
        chk("act_STATUS", status, 4'b0001);
        chk("act_SETPULSE", setpulse, 4'b0001);
        @(negedge clk);
        wstb = 1'b0;
        repeat (4) @(negedge clk);
        check_state();
        rd(1'b0, 4'h0);

        // Fill all four slots, then drain them
        wr(1'b1, 4'h0);
        wr(1'b0, 4'h1);
        wr(1'b0, 4'h2);
        wr(1'b0, 4'h3);
        wr(1'b0, 4'h4);
        chk("full_STATUS", status, 4'b1111);
        rd(1'b1, 4'h0);
        for (int i = 0; i < 4; i++) rd(1'b0, 4'h0);

        // Pointer write and wrap
        wr(1'b1, 4'h3);
        wr(1'b0, 4'hA);
        wr(1'b0, 4'hB);
        chk("wrap_STATUS", status, 4'b1001);
        rd(1'b1, 4'h3);
        rd(1'b0, 4'h0);
        rd(1'b0, 4'h0);

        // Overwrite sets OVF, reader control clears it
        wr(1'b1, 4'h0);
        wr(1'b0, 4'h7);
        wr(1'b1, 4'h0);
        wr(1'b0, 4'h9);
        chk("ovf_set", ovf, 1);
        rd(1'b1, 4'h8);
        chk("ovf_cleared", ovf, 0);
        rd(1'b0, 4'h0);

        // Same-cycle write and read of slot 2
        wr(1'b1, 4'h2);
        wr(1'b0, 4'h4);
        wr(1'b1, 4'h2);
        rd(1'b1, 4'h2);
        both(1'b0, 4'h6, 1'b0, 4'h0);
        chk("same_STATUS2", status[2], 1);
        chk("same_OVF", ovf, 0);
        rd(1'b1, 4'h2);
        rd(1'b0, 4'h0);

        // Overflow and OVF-clear in the same cycle: set wins
        wr(1'b1, 4'h0);
        wr(1'b0, 4'h1);
        wr(1'b1, 4'h0);
        both(1'b0, 4'h2, 1'b1, 4'h8);
        chk("ovf_set_wins", ovf, 1);

        // Reset between strobe rise and action
        wsel = 1'b0;
        wdin = 4'hE;
        @(negedge clk);
        wstb = 1'b1;
        @(negedge clk);
        rst_tick = 1'b1;
        @(negedge clk);
        chk_all_zero("midreset");
        model_reset();
        @(negedge clk);
        rst_tick = 1'b0;
        repeat (6) @(negedge clk);
        chk_all_zero("post_release");
        wstb = 1'b0;
        repeat (4) @(negedge clk);
        check_state();

        // Empty slot reads back its reset contents without error
        rd(1'b0, 4'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc060ha_nibble_mailbox.md
Name: pc060ha_nibble_mailbox

Overview:
- One-direction nibble mailbox between a writer CPU (e.g. the 68000) and a reader CPU (e.g. the Z80) in the PC060HA sound-comm path.
- Holds SLOTS nibble registers, each with a full flag: a writer data strobe sets the slot's flag, a reader data strobe clears it.
- Raises a level IRQ to the reader.
- Fully synchronous to CLK, with strobe synchronizers and edge detection.
- Instantiate twice, once per direction.

Parameters:
- DW, 4, data width of each slot
- SLOTS, 4, number of slots; power of 2, minimum 2
- PW, 2, pointer width; must equal log2(SLOTS)
- SYNC, 2, synchronizer depth on WSTB/RSTB; 0 means strobes are already CLK-synchronous
- IRQ_SLOT, 3, slot whose full flag drives IRQ

Ports:
- CLK  in  1  system clock
- RESETTICK  in  1  reset, asynchronous, active-high
- WSTB  in  1  writer strobe, level; action on rising edge
- WSEL  in  1  writer select: 1 = pointer write, 0 = data write
- WDIN  in  DW  writer data / pointer value (low PW bits)
- RSTB  in  1  reader strobe, level; action on rising edge
- RSEL  in  1  reader select: 1 = pointer write / control, 0 = data read
- RDIN  in  DW  reader pointer value (low PW bits); bit DW-1 = OVF clear when RSEL=1
- RDOUT  out  DW  registered read data
- RDVALID  out  1  one-cycle pulse when RDOUT updates
- STATUS  out  SLOTS  full flags, bit n = slot n
- OVF  out  1  sticky overwrite error
- IRQ  out  1  equals STATUS[IRQ_SLOT]
- SETPULSE  out  SLOTS  one-cycle pulse on the slot just written
- CLRPULSE  out  SLOTS  one-cycle pulse on the slot just read

Behaviour:
Reset (RESETTICK high, asynchronous):
- slots, STATUS, wptr, rptr, RDOUT, RDVALID, OVF, SETPULSE, CLRPULSE are all 0.
- Synchronizer and edge-history flops reset to all-1s. A strobe held high across reset release therefore generates no event until it has gone low and high again.

Strobe handling:
- WSTB and RSTB each pass through SYNC flops, then a history flop.
- An event is the synchronized value being 1 while history is 0.
- The action occurs on the CLK edge after event detection, i.e. SYNC+1 cycles after the strobe rises.
- WSEL/WDIN and RSEL/RDIN are sampled at the action cycle. They must be stable from the strobe's rising edge for at least SYNC+2 cycles; this is the caller's obligation and is not checked.

Writer events:
- WSEL=1: wptr <= WDIN[PW-1:0]. No flag change, no pulse.
- WSEL=0: slot[wptr] <= WDIN; STATUS[wptr] <= 1; SETPULSE[wptr] = 1 for one cycle; wptr <= wptr+1 modulo SLOTS (SLOTS-1 wraps to 0).
- Write to a slot whose flag is already 1: data is overwritten and OVF <= 1.

Reader events:
- RSEL=1: rptr <= RDIN[PW-1:0]. If RDIN[DW-1]=1, also OVF <= 0.
- RSEL=0: RDOUT <= slot[rptr]; RDVALID = 1 for one cycle; STATUS[rptr] <= 0; CLRPULSE[rptr] = 1; rptr <= rptr+1 modulo SLOTS.
- Reading an empty slot: returns the stale slot contents, flag stays 0, no error.

Simultaneous events in the same cycle:
- Write and read of the same slot: RDOUT gets the old data; the slot gets the new data; the flag ends at 1 (set wins); both pulses fire; OVF is unaffected.
- Writer overflow and reader OVF-clear: set wins, OVF = 1.
- Different slots: the events are independent.

Pointer writes never touch slot data. The two pointers are fully independent.

IRQ is combinational from the STATUS register and cannot glitch.

Test Plan:
- Reset with WSTB held high, then release: no write occurs; drop WSTB and raise it with WSEL=0, WDIN=5 → slot0=5, STATUS=0001, SETPULSE=0001, wptr=1; action lands exactly SYNC+1 cycles after the rise.
- Write 1,2,3,4 sequentially → STATUS=1111 and IRQ=1. Reader performs 4 data reads → RDOUT 1,2,3,4 with 4 RDVALID pulses, STATUS=0000, IRQ=0, rptr wrapped to 0.
- Writer pointer write 3, then data A, then data B → slot3=A, slot0=B (wrap), STATUS=1001.
- Write slot0=7, write the pointer back to 0, write 9 → OVF=1 and slot0=9. Reader RSEL=1 with RDIN=8 → OVF=0 and rptr=0.
- Same-cycle write of 6 and read on slot2 (old value 4) → RDOUT=4, slot2=6, STATUS[2]=1, both pulses fire.
- Assert RESETTICK mid-sequence between strobe rise and action → no action after release, all outputs 0.
